// File: rtl/pla_onset_extractor.sv
// pla_onset_extractor: sweeps every input vector of an N_IN-input, single-output
// function under test, samples its response after SETTLE cycles, and streams the
// ON-set minterms out in ascending order over a valid/ready handshake.
// Optional feature macro: PLA_ONSET_SIG_EN enables a CRC-16-CCITT style signature
// over the sampled truth table; without it the signature output is tied to zero.
module pla_onset_extractor #(
  parameter int N_IN   = 10,
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [N_IN-1:0]   dut_x,
  input  logic              dut_y,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [N_IN-1:0]   m_data,
  output logic [N_IN:0]     onset_cnt,
  output logic [15:0]       signature
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    EMIT,
    FINISH
  } state_t;

  state_t            state_q;
  logic              busy_q;
  logic              done_q;
  logic [N_IN-1:0]   dutX_q;
  logic              mValid_q;
  logic [N_IN-1:0]   mData_q;
  logic [N_IN:0]     onsetCnt_q;
  logic [SW-1:0]     settle_q;
  logic              lastVec;

  assign lastVec = (dutX_q == {N_IN{1'b1}});

`ifdef PLA_ONSET_SIG_EN
  logic [15:0] sig_q;
  logic [15:0] sig_d;
  logic        sigFb;

  // Next signature value: one CRC-16-CCITT shift step folding in the sampled response.
  always_comb begin
    sigFb = sig_q[15] ^ dut_y;
    sig_d = {sig_q[14:0], 1'b0} ^ (sigFb ? 16'h1021 : 16'h0000);
  end

  assign signature = sig_q;
`else
  assign signature = 16'h0000;
`endif

  // Sweep controller: walks the vectors, holds each for SETTLE cycles, samples the
  // response and keeps an ON vector on m_data (and dut_x) until it is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dutX_q     <= '0;
      mValid_q   <= 1'b0;
      mData_q    <= '0;
      onsetCnt_q <= '0;
      settle_q   <= '0;
`ifdef PLA_ONSET_SIG_EN
      sig_q      <= 16'h0000;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= DRIVE;
            busy_q     <= 1'b1;
            dutX_q     <= '0;
            onsetCnt_q <= '0;
            settle_q   <= '0;
`ifdef PLA_ONSET_SIG_EN
            sig_q      <= 16'hFFFF;
`endif
          end
        end
        DRIVE: begin
          if (settle_q == SETTLE_LAST) begin
            state_q <= SAMPLE;
          end else begin
            settle_q <= settle_q + 1'b1;
          end
        end
        SAMPLE: begin
`ifdef PLA_ONSET_SIG_EN
          sig_q <= sig_d;
`endif
          if (dut_y) begin
            state_q  <= EMIT;
            mValid_q <= 1'b1;
            mData_q  <= dutX_q;
          end else if (lastVec) begin
            state_q <= FINISH;
            done_q  <= 1'b1;
          end else begin
            dutX_q   <= dutX_q + 1'b1;
            settle_q <= '0;
            state_q  <= DRIVE;
          end
        end
        EMIT: begin
          if (m_ready) begin
            mValid_q   <= 1'b0;
            onsetCnt_q <= onsetCnt_q + 1'b1;
            if (lastVec) begin
              state_q <= FINISH;
              done_q  <= 1'b1;
            end else begin
              dutX_q   <= dutX_q + 1'b1;
              settle_q <= '0;
              state_q  <= DRIVE;
            end
          end
        end
        FINISH: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign dut_x     = dutX_q;
  assign m_valid   = mValid_q;
  assign m_data    = mData_q;
  assign onset_cnt = onsetCnt_q;

endmodule

// File: tb/tb_pla_onset_extractor.sv
// tb_pla_onset_extractor: randomized truth tables driven into the sweeper; expected
// minterms are queued at start and a monitor pops them on every handshake.
module tb_pla_onset_extractor;

  localparam int N_IN   = 10;
  localparam int SETTLE = 1;
  localparam int NV     = 1 << N_IN;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              busy;
  logic              done;
  logic [N_IN-1:0]   dut_x;
  logic              dut_y;
  logic              m_valid;
  logic              m_ready;
  logic [N_IN-1:0]   m_data;
  logic [N_IN:0]     onset_cnt;
  logic [15:0]       signature;

  bit   tt [NV];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   stallCnt = 0;
  int   expQ [$];
  int   readyMode = 0;
  bit   autoReady = 1'b1;
  bit   manualReady = 1'b1;

  pla_onset_extractor #(.N_IN(N_IN), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .dut_x(dut_x), .dut_y(dut_y), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .onset_cnt(onset_cnt), .signature(signature)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Cycle counter used for latency measurements.
  always @(posedge clk) cyc <= cyc + 1;

  // Function under test: a lookup into the current truth table.
  always_comb dut_y = tt[dut_x];

  // Downstream ready: either directly controlled by the main sequence or automatic.
  always_comb m_ready = (readyMode == 2) ? manualReady : autoReady;

  // Automatic ready source: always high, or randomly throttled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      autoReady = (readyMode == 1) ? ($urandom_range(3) != 0) : 1'b1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h time=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the expected minterm on each handshake and checks stream stability.
  initial begin
    bit pend;
    logic [N_IN-1:0] pd;
    int e;
    pend = 1'b0;
    pd = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          checkOutput("validHeld", 32'(m_valid), 32'd1);
          if (m_valid) checkOutput("dataStable", 32'(m_data), 32'(pd));
        end
        if (m_valid) begin
          checkOutput("dutXMatchesData", 32'(dut_x), 32'(m_data));
          if (m_ready) begin
            if (expQ.size() == 0) begin
              checks++;
              failures++;
              $display("[TB] FAIL unexpectedBeat actual=0x%0h required=none", m_data);
            end else begin
              e = expQ.pop_front();
              checkOutput("mData", 32'(m_data), 32'(e));
            end
            pend = 1'b0;
          end else begin
            stallCnt++;
            pend = 1'b1;
            pd = m_data;
          end
        end else begin
          pend = 1'b0;
        end
      end
    end
  end

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_dutX"}, 32'(dut_x), 32'd0);
    checkOutput({tag, "_mValid"}, 32'(m_valid), 32'd0);
    checkOutput({tag, "_mData"}, 32'(m_data), 32'd0);
    checkOutput({tag, "_onsetCnt"}, 32'(onset_cnt), 32'd0);
    checkOutput({tag, "_signature"}, 32'(signature), 32'd0);
  endtask

  task automatic waitForX(input int target, output bit hit);
    hit = 1'b0;
    for (int k = 0; k < 5000; k++) begin
      @(negedge clk);
      if (int'(dut_x) == target) begin
        hit = 1'b1;
        break;
      end
    end
    checkOutput("reachVector", 32'(hit), 32'd1);
  endtask

  // mode: 0 const0, 1 const1, 2 parity, 3 random, 4 only vector 5 is ON.
  // variant: 0 plain, 1 backpressure at vector 5, 2 start while busy, 3 reset at 300.
  task automatic applyStimulus(input int mode, input int variant, input int rmode);
    int expOn;
    int expLat;
    int stall0;
    int startCyc;
    logic [15:0] crc;
    logic [15:0] expSig;
    bit fb;
    bit got;
    bit hit;

    for (int v = 0; v < NV; v++) begin
      case (mode)
        0: tt[v] = 1'b0;
        1: tt[v] = 1'b1;
        2: tt[v] = ($countones(v) % 2) == 1;
        3: tt[v] = 1'($urandom_range(1));
        default: tt[v] = (v == 5);
      endcase
    end

    expQ.delete();
    expOn = 0;
    crc = 16'hFFFF;
    for (int v = 0; v < NV; v++) begin
      if (tt[v]) begin
        expQ.push_back(v);
        expOn++;
      end
      fb = crc[15] ^ tt[v];
      crc = {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
`ifdef PLA_ONSET_SIG_EN
    expSig = crc;
`else
    expSig = 16'h0000;
`endif

    readyMode = rmode;
    manualReady = (variant == 1) ? 1'b0 : 1'b1;

    @(posedge clk);
    #1;
    start = 1'b1;
    startCyc = cyc;
    stall0 = stallCnt;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    checkOutput("busyAfterStart", 32'(busy), 32'd1);

    if (variant == 1) begin
      got = 1'b0;
      for (int k = 0; k < 100; k++) begin
        if (m_valid) begin
          got = 1'b1;
          break;
        end
        @(negedge clk);
      end
      checkOutput("bpValidSeen", 32'(got), 32'd1);
      for (int i = 0; i < 6; i++) begin
        if (i > 0) begin
          @(posedge clk);
          #1;
          if (i == 5) manualReady = 1'b1;
          @(negedge clk);
        end
        checkOutput("bpValid", 32'(m_valid), 32'd1);
        checkOutput("bpData", 32'(m_data), 32'd5);
        checkOutput("bpDutX", 32'(dut_x), 32'd5);
      end
      @(negedge clk);
      checkOutput("bpValidDrop", 32'(m_valid), 32'd0);
      checkOutput("bpCount", 32'(onset_cnt), 32'd1);
    end

    if (variant == 2) begin
      waitForX(100, hit);
      @(posedge clk);
      #1;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      checkOutput("startIgnoredBusy", 32'(busy), 32'd1);
      checkOutput("startIgnoredNoRestart", 32'(dut_x >= 10'd100), 32'd1);
    end

    if (variant == 3) begin
      waitForX(300, hit);
      #2;
      rst_n = 1'b0;
      #1;
      checkResetValues("midReset");
      expQ.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      checkResetValues("afterMidReset");
      readyMode = 0;
      return;
    end

    got = 1'b0;
    for (int k = 0; k < 20000; k++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    checkOutput("doneSeen", 32'(got), 32'd1);
    if (got) begin
      expLat = 1 + NV * (SETTLE + 1) + expOn + (stallCnt - stall0);
      checkOutput("doneLatency", 32'(cyc - startCyc), 32'(expLat));
      checkOutput("onsetCnt", 32'(onset_cnt), 32'(expOn));
      checkOutput("signature", 32'(signature), 32'(expSig));
      checkOutput("allBeatsSeen", 32'(expQ.size()), 32'd0);
      @(negedge clk);
      checkOutput("donePulse", 32'(done), 32'd0);
      checkOutput("busyCleared", 32'(busy), 32'd0);
      checkOutput("onsetCntHold", 32'(onset_cnt), 32'(expOn));
    end
    readyMode = 0;
    manualReady = 1'b1;
  endtask

  // Main sequence: reset, then a series of sweeps with different truth tables.
  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkResetValues("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkResetValues("idle");

    applyStimulus(0, 0, 0);
    applyStimulus(1, 0, 0);
    applyStimulus(2, 0, 0);
    applyStimulus(4, 1, 2);
    applyStimulus(3, 2, 1);
    applyStimulus(3, 3, 0);
    applyStimulus(3, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
